// File: rtl/reg_file_pkg.sv
// Shared types and register-number constants for the register file slice.
package reg_file_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_V0   = 5'd2;
  localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_hilo.sv
// HI/LO register pair: both halves always update together on one enable.
module hilo_reg
  import reg_file_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_out <= RESET_VALUE;
      lo_out <= RESET_VALUE;
    end else if (wr_en) begin
      hi_out <= hi_in;
      lo_out <= lo_in;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32x32 general register file with HI/LO, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  reg_addr_t   rs_addr,
  input  reg_addr_t   rt_addr,
  output logic [31:0] a,
  output logic [31:0] b,
  input  logic        wr_en,
  input  reg_addr_t   wr_addr,
  input  logic [31:0] wr_data,
  input  logic        hilo_wr_en,
  input  logic [31:0] hi_wr_data,
  input  logic [31:0] lo_wr_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] register_v0
);

  logic [31:0] regs [32];
  logic [31:0] stored_a;
  logic [31:0] stored_b;

  // Entry 0 is held at zero and never written; the read mux also forces it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= (i == 0) ? '0 : RESET_VALUE;
      end
    end else if (wr_en && (wr_addr != REG_ZERO)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    stored_a = (rs_addr == REG_ZERO) ? '0 : regs[rs_addr];
    stored_b = (rt_addr == REG_ZERO) ? '0 : regs[rt_addr];
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  always_comb begin
    fwd_ok = wr_en && !reset && (wr_addr != REG_ZERO);
    a = stored_a;
    b = stored_b;
    if (fwd_ok && (wr_addr == rs_addr)) a = wr_data;
    if (fwd_ok && (wr_addr == rt_addr)) b = wr_data;
  end
`else
  always_comb begin
    a = stored_a;
    b = stored_b;
  end
`endif

  assign register_v0 = regs[REG_V0];

  hilo_reg #(
    .RESET_VALUE(RESET_VALUE)
  ) u_hilo (
    .clk   (clk),
    .reset (reset),
    .wr_en (hilo_wr_en),
    .hi_in (hi_wr_data),
    .lo_in (lo_wr_data),
    .hi_out(hi),
    .lo_out(lo)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: scoreboard of expected read values against a register model.
`timescale 1ns/1ps
module tb_reg_file;
  import reg_file_pkg::*;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  reg_addr_t   rs_addr, rt_addr, wr_addr;
  logic [31:0] a, b, wr_data, hi_wr_data, lo_wr_data, hi, lo, register_v0;
  logic        wr_en, hilo_wr_en;

  reg_file #(.RESET_VALUE(RV)) dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .a(a), .b(b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hilo_wr_en(hilo_wr_en), .hi_wr_data(hi_wr_data), .lo_wr_data(lo_wr_data),
    .hi(hi), .lo(lo), .register_v0(register_v0)
  );

  // Clock starts late so the reset checks happen with no edge at all.
  initial begin
    clk = 1'b0;
    #50;
    forever #5 clk = ~clk;
  end

  typedef enum int unsigned {SEL_A, SEL_B, SEL_HI, SEL_LO, SEL_V0} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t    sb[$];
  logic [31:0] mdl [32];
  logic [31:0] mhi, mlo;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_val(input string tag, input sel_t sel, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic drain();
    sb_item_t    it;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.sel)
        SEL_A:   obs = a;
        SEL_B:   obs = b;
        SEL_HI:  obs = hi;
        SEL_LO:  obs = lo;
        default: obs = register_v0;
      endcase
      check(it.tag, obs, it.exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input reg_addr_t ad);
    if (ad == REG_ZERO) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !reset && (wr_addr != REG_ZERO) && (wr_addr == ad)) return wr_data;
`endif
    return mdl[ad];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = (i == 0) ? '0 : RV;
    mhi = RV;
    mlo = RV;
  endtask

  // One clock: expectations from the model, sample at negedge, update model at posedge.
  task automatic cycle();
    expect_val("mdl_a",  SEL_A,  exp_rd(rs_addr));
    expect_val("mdl_b",  SEL_B,  exp_rd(rt_addr));
    expect_val("mdl_hi", SEL_HI, mhi);
    expect_val("mdl_lo", SEL_LO, mlo);
    expect_val("mdl_v0", SEL_V0, mdl[REG_V0]);
    @(negedge clk);
    drain();
    @(posedge clk);
    if (wr_en && (wr_addr != REG_ZERO)) mdl[wr_addr] = wr_data;
    if (hilo_wr_en) begin
      mhi = hi_wr_data;
      mlo = lo_wr_data;
    end
    #1;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; hilo_wr_en = 1'b0;
    rs_addr = '0; rt_addr = '0; wr_addr = '0;
    wr_data = '0; hi_wr_data = '0; lo_wr_data = '0;

    // Asynchronous reset with no clock edge.
    #2 reset = 1'b1;
    #1;
    expect_val("rst_hi", SEL_HI, RV);
    expect_val("rst_lo", SEL_LO, RV);
    expect_val("rst_v0", SEL_V0, RV);
    drain();
    for (int i = 0; i < 32; i++) begin
      rs_addr = reg_addr_t'(i);
      rt_addr = reg_addr_t'(31 - i);
      #1;
      expect_val("rst_a", SEL_A, (i == 0) ? 32'h0 : RV);
      expect_val("rst_b", SEL_B, (i == 31) ? 32'h0 : RV);
      drain();
    end
    model_reset();
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // Write reg 2, read it on both ports next cycle.
    wr_en = 1'b1; wr_addr = REG_V0; wr_data = 32'h1234_5678;
    rs_addr = REG_V0; rt_addr = REG_V0;
    cycle();
    wr_en = 1'b0;
    expect_val("v0_a",  SEL_A,  32'h1234_5678);
    expect_val("v0_b",  SEL_B,  32'h1234_5678);
    expect_val("v0_v0", SEL_V0, 32'h1234_5678);
    cycle();

    // Writes to reg 0 are discarded, never forwarded.
    wr_en = 1'b1; wr_addr = REG_ZERO; wr_data = 32'hFFFF_FFFF;
    rs_addr = REG_ZERO; rt_addr = REG_ZERO;
    expect_val("z_same_a", SEL_A, 32'h0);
    cycle();
    wr_en = 1'b0;
    expect_val("z_a", SEL_A, 32'h0);
    expect_val("z_b", SEL_B, 32'h0);
    cycle();

    // Same-cycle read of the register being written.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1;
    cycle();
    wr_data = 32'hA5A5_A5A5; rs_addr = 5'd5; rt_addr = 5'd5;
`ifdef REGFILE_BYPASS_EN
    expect_val("byp_a", SEL_A, 32'hA5A5_A5A5);
    expect_val("byp_b", SEL_B, 32'hA5A5_A5A5);
`else
    expect_val("old_a", SEL_A, 32'h1);
    expect_val("old_b", SEL_B, 32'h1);
`endif
    cycle();
    wr_en = 1'b0;
    expect_val("new_a", SEL_A, 32'hA5A5_A5A5);
    expect_val("new_b", SEL_B, 32'hA5A5_A5A5);
    cycle();

    // register_v0 shows stored value only.
    wr_en = 1'b1; wr_addr = REG_V0; wr_data = 32'hCAFE_F00D; rs_addr = REG_V0;
    expect_val("v0_nobyp", SEL_V0, 32'h1234_5678);
    cycle();
    wr_en = 1'b0;
    expect_val("v0_upd", SEL_V0, 32'hCAFE_F00D);
    cycle();

    // Concurrent HI/LO and general write.
    hilo_wr_en = 1'b1; hi_wr_data = 32'h1; lo_wr_data = 32'h2;
    wr_en = 1'b1; wr_addr = REG_RA; wr_data = 32'h3;
    rs_addr = REG_RA; rt_addr = REG_V0;
    expect_val("hi_old", SEL_HI, RV);
    expect_val("lo_old", SEL_LO, RV);
    cycle();
    hilo_wr_en = 1'b0; wr_en = 1'b0;
    expect_val("hi_new", SEL_HI, 32'h1);
    expect_val("lo_new", SEL_LO, 32'h2);
    expect_val("ra_new", SEL_A,  32'h3);
    cycle();

    // Randomised traffic against the model.
    for (int n = 0; n < 60; n++) begin
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = reg_addr_t'($urandom_range(0, 31));
      wr_data    = $urandom;
      hilo_wr_en = 1'($urandom_range(0, 1));
      hi_wr_data = $urandom;
      lo_wr_data = $urandom;
      rs_addr    = ($urandom_range(0, 2) == 0) ? wr_addr : reg_addr_t'($urandom_range(0, 31));
      rt_addr    = ($urandom_range(0, 2) == 0) ? wr_addr : reg_addr_t'($urandom_range(0, 31));
      cycle();
    end
    wr_en = 1'b0; hilo_wr_en = 1'b0;

    // Reset asserted mid-cycle during a write: write lost, reset wins.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h77; rs_addr = 5'd4; rt_addr = 5'd4;
    #2 reset = 1'b1;
    #1;
    expect_val("mrst_a",  SEL_A,  RV);
    expect_val("mrst_b",  SEL_B,  RV);
    expect_val("mrst_hi", SEL_HI, RV);
    expect_val("mrst_lo", SEL_LO, RV);
    expect_val("mrst_v0", SEL_V0, RV);
    drain();
    @(posedge clk);
    #1 wr_en = 1'b0;
    @(negedge clk) reset = 1'b0;
    #1;
    expect_val("post_rst_a", SEL_A, RV);
    drain();
    model_reset();
    @(posedge clk);
    #1;

    // First edge after reset release performs a normal write.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h99;
    cycle();
    wr_en = 1'b0;
    expect_val("first_wr", SEL_A, 32'h99);
    cycle();

    if (sb.size() != 0) check("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter RESET_VALUE, default 32'h0000_0000, value loaded into every general register and into HI/LO on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rs_addr  input  5  read port A address (instruction rs field).
REQ-005 rt_addr  input  5  read port B address (instruction rt field).
REQ-006 a  output  32  read port A data; drives ALU operand a.
REQ-007 b  output  32  read port B data; drives ALU operand b (before immediate mux).
REQ-008 wr_en  input  1  general-register write enable.
REQ-009 wr_addr  input  5  general-register write address.
REQ-010 wr_data  input  32  general-register write data (ALU result or load data).
REQ-011 hilo_wr_en  input  1  HI/LO pair write enable.
REQ-012 hi_wr_data  input  32  next HI value.
REQ-013 lo_wr_data  input  32  next LO value.
REQ-014 hi  output  32  current HI.
REQ-015 lo  output  32  current LO.
REQ-016 register_v0  output  32  current stored value of register 2, for test harness.

Function
REQ-017 The block SHALL hold 32 general registers of 32 bits plus HI and LO.
REQ-018 Reads SHALL be combinational: a = reg[rs_addr], b = reg[rt_addr], zero-cycle latency.
REQ-019 Address 0 SHALL read as 32'h0 on both ports at all times, including directly after reset with nonzero RESET_VALUE.
REQ-020 On a rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] SHALL take wr_data; wr_addr=0 writes SHALL be discarded.
REQ-021 On a rising edge with hilo_wr_en=1, HI and LO SHALL both update in the same edge; partial update is not permitted.
REQ-022 General and HI/LO writes in the same cycle SHALL both take effect; they are independent.
REQ-023 Both read ports addressing the same register SHALL return identical data.
REQ-024 Without bypass (see Configuration), a read of the register being written in the same cycle SHALL return the old value; the new value appears the cycle after the edge.
REQ-025 register_v0 SHALL reflect stored reg[2] only; it is never bypassed.
REQ-026 hi/lo SHALL reflect stored values only; they are never bypassed.

Reset
REQ-027 reset=1 SHALL immediately, without a clock edge, set reg[1..31], HI and LO to RESET_VALUE; all outputs follow combinationally.
REQ-028 A write coinciding with asserted reset SHALL be lost; reset takes priority.
REQ-029 After reset deasserts, the first rising edge SHALL perform normal writes.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN: when defined, if wr_en=1, wr_addr!=0 and wr_addr equals rs_addr (rt_addr), a (b) SHALL output wr_data in the same cycle; when undefined, REQ-024 applies.
REQ-031 Bypass SHALL never apply to address 0, nor while reset=1.

Structure
REQ-032 Shared package SHALL hold typedef reg_addr_t (5-bit) and constants REG_ZERO=0, REG_V0=2, REG_RA=31; ports rs_addr, rt_addr, wr_addr use reg_addr_t.
REQ-033 HI/LO storage SHALL be a sub-module hilo_reg (clk, reset, wr_en, hi/lo in, hi/lo out); the general array stays inline.

Verification
REQ-034 Reset pulse with RESET_VALUE=32'hDEAD_BEEF -> reg 0 reads 0, regs 1..31, hi, lo, register_v0 read 32'hDEAD_BEEF without any clock edge.
REQ-035 Write 32'h1234_5678 to reg 2, then read rs=2, rt=2 -> a=b=register_v0=32'h1234_5678 next cycle.
REQ-036 Write 32'hFFFF_FFFF to reg 0 -> a with rs_addr=0 stays 32'h0.
REQ-037 Same-cycle write 32'hA5A5_A5A5 to reg 5 with rs_addr=5 (old 32'h1) -> a=32'h1 without macro, 32'hA5A5_A5A5 with REGFILE_BYPASS_EN; both show 32'hA5A5_A5A5 next cycle.
REQ-038 hilo_wr_en=1, hi=32'h1, lo=32'h2, with wr_en to reg 31 (32'h3) same edge -> hi=1, lo=2, reg 31=3.
REQ-039 Assert reset asynchronously mid-cycle during a write of 32'h77 to reg 4 -> reg 4 equals RESET_VALUE after reset releases.
